exe_muldiv_seq: RTL
===================

Name: exe_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that borrows the EXE-stage ALU for one add or subtract per cycle.
- Sits beside the EXE stage. While it owns the ALU (alu_own=1) it drives EXE_CMD/val1/val2 through the EXE input mux and holds the pipeline via stall.
- Unsigned 32-bit ops only:
  - MUL returns the low 32 bits of the product.
  - DIV returns quotient and remainder.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  1  0=MUL, 1=DIV; sampled with start
- abort  input  1  synchronous cancel (pipeline flush)
- a  input  32  multiplicand / dividend; sampled with start
- b  input  32  multiplier / divisor; sampled with start
- alu_result  input  32  EXE ALU output
- alu_cmd  output  5  EXE_CMD driven to the ALU
- alu_val1  output  32  ALU val1
- alu_val2  output  32  ALU val2
- alu_own  output  1  1 = EXE input mux selects this block
- stall  output  1  freeze IF/ID/EXE; equals busy
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, results valid
- result_lo  output  32  MUL product low / DIV quotient
- result_hi  output  32  MUL: 0 / DIV: remainder

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0 (alu_cmd=ALU_ADD=0); internal regs 0. Reset mid-operation discards the operation and no done is produced.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 latches a, b, op; clears counter and accumulator.
  - Next state is MUL, or DIV if op=1.
  - DIV with b=0 goes to FIN directly: result_lo=32'hFFFFFFFF, result_hi=a.
- MUL (32 cycles, i=0..31):
  - alu_own=1; alu_cmd=ALU_ADD; alu_val1=acc; alu_val2 = mplier[0] ? mcand : 0.
  - Each cycle: acc<=alu_result (mod 2^32), mcand<=mcand<<1, mplier<=mplier>>1.
  - After i=31 go to FIN with result_lo=acc, result_hi=0.
- DIV (32 cycles, restoring, MSB first):
  - part = {rem,dvd[31]}, 33 bits.
  - alu_own=1; alu_cmd=ALU_SUB; alu_val1=part[31:0]; alu_val2=divisor.
  - ge = (part >= {1'b0,divisor}) is computed internally, not by the ALU.
  - rem <= ge ? alu_result : part[31:0]; quotient bit = ge; dvd <= dvd<<1.
  - After 32 cycles go to FIN with result_lo=quotient, result_hi=rem.
- FIN: done=1 for one cycle; alu_own=0; busy=0. Next state IDLE.
- busy/stall =1 in MUL, DIV and FIN-entry cycles, i.e. from the cycle after start until the cycle before done.
- Latency: start sampled at edge 0 → done high in cycle 33, or cycle 1 for divide-by-zero.
- result_lo/result_hi hold their values until the next accepted start. They are only updated on entry to FIN.
- start while not IDLE: ignored, with no queuing.
- abort: in MUL/DIV/FIN returns to IDLE at the next edge. No done is produced and results are unchanged. abort has priority over start in the same cycle. abort in IDLE has no effect.
- When alu_own=0: alu_val1/alu_val2 = 0 and alu_cmd = ALU_ADD.
- The ALU is combinational: alu_result is used in the same cycle it is driven.

Decomposition:
- Shared package exe_pkg holds:
  - ALU command constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_NOR=4, ALU_XOR=5, ALU_SLL=6, ALU_SLA=7, ALU_SRL=8, ALU_SRA=9, ALU_MEMADDR=16.
  - OP_MUL=0 and OP_DIV=1.
  - State encoding enum muldiv_state_t.
- Single module; no sub-module needed. The bench instantiates the real EXE-stage ALU combinationally on alu_cmd/val1/val2 → alu_result.

Test Plan:
- MUL a=7, b=6: done in cycle 33 with result_lo=42, result_hi=0; stall=1 for cycles 1–32; alu_cmd=0 throughout.
- MUL a=b=32'hFFFFFFFF: result_lo=32'h00000001, result_hi=0. Also check a=32'h80000000, b=2: result_lo=0.
- DIV a=100, b=7: result_lo=14, result_hi=2; alu_cmd=1 throughout. Also DIV a=32'hFFFFFFFF, b=1: q=32'hFFFFFFFF, r=0.
- DIV a=123, b=0: done in cycle 1 with result_lo=32'hFFFFFFFF, result_hi=123; no ALU ownership.
- Start DIV 100/7, pulse start (MUL 3×3) in cycle 10: second start ignored; result 14/2. Then abort in cycle 5 of a new op: IDLE next cycle, no done, results still 14/2.
- Assert rst=0 asynchronously mid-MUL: all outputs 0 immediately. After release, MUL 5×5 gives 25.

Source files
------------

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared EXE-stage ALU commands, op codes and muldiv state encoding
package exe_pkg;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_AND     = 5'd2;
  localparam logic [4:0] ALU_OR      = 5'd3;
  localparam logic [4:0] ALU_NOR     = 5'd4;
  localparam logic [4:0] ALU_XOR     = 5'd5;
  localparam logic [4:0] ALU_SLL     = 5'd6;
  localparam logic [4:0] ALU_SLA     = 5'd7;
  localparam logic [4:0] ALU_SRL     = 5'd8;
  localparam logic [4:0] ALU_SRA     = 5'd9;
  localparam logic [4:0] ALU_MEMADDR = 5'd16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/exe_muldiv_seq.sv
// rtl/exe_muldiv_seq.sv - iterative unsigned mul/div that borrows the EXE ALU one add/sub per cycle
module exe_muldiv_seq
  import exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [4:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_val1,
  output logic [WIDTH-1:0] alu_val2,
  output logic             alu_own,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  muldiv_state_t state, state_next;

  // acc doubles as the divide remainder, opnd as the divisor, shreg as the dividend
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] quot;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   part;
  logic             ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quot;
  logic             accept;
  logic             last;

  assign part     = {acc, shreg[WIDTH-1]};
  assign ge       = (part >= {1'b0, opnd});
  assign div_rem  = ge ? alu_result : part[WIDTH-1:0];
  assign div_quot = {quot[WIDTH-2:0], ge};
  assign accept   = start && !abort;
  assign last     = (cnt == CNT_LAST);
  assign stall    = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_own    = 1'b0;
    alu_cmd    = ALU_ADD;
    alu_val1   = '0;
    alu_val2   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_DIV) state_next = (b == '0) ? ST_FIN : ST_DIV;
          else              state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        busy     = 1'b1;
        alu_own  = 1'b1;
        alu_val1 = acc;
        alu_val2 = shreg[0] ? opnd : '0;
        if (abort)     state_next = ST_IDLE;
        else if (last) state_next = ST_FIN;
      end
      ST_DIV: begin
        busy     = 1'b1;
        alu_own  = 1'b1;
        alu_cmd  = ALU_SUB;
        alu_val1 = part[WIDTH-1:0];
        alu_val2 = opnd;
        if (abort)     state_next = ST_IDLE;
        else if (last) state_next = ST_FIN;
      end
      ST_FIN: begin
        done       = !abort;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      opnd      <= '0;
      shreg     <= '0;
      quot      <= '0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= '0;
            opnd  <= b;
            shreg <= a;
            quot  <= '0;
            cnt   <= '0;
            if (op == OP_DIV && b == '0) begin
              result_lo <= '1;
              result_hi <= a;
            end
          end
        end
        ST_MUL: begin
          if (!abort) begin
            acc   <= alu_result;
            opnd  <= opnd << 1;
            shreg <= shreg >> 1;
            cnt   <= cnt + 1'b1;
            if (last) begin
              result_lo <= alu_result;
              result_hi <= '0;
            end
          end
        end
        ST_DIV: begin
          if (!abort) begin
            acc   <= div_rem;
            quot  <= div_quot;
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
            if (last) begin
              result_lo <= div_quot;
              result_hi <= div_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
